// File: rtl/cache_row_dispatch_if.sv
// Signal bundle between one block cache, its row dispatcher and the two PE row consumers.
// "master" is the dispatcher side; "slave" is the cache plus consumer side.
interface cache_row_dispatch_if #(
    parameter int CACHE_WIDTH = 162,
    parameter int ROW_BITS    = 80,
    parameter int ROW_W       = 4
);
    logic                   empty;
    logic [CACHE_WIDTH-1:0] cache_data;
    logic                   read_req;

    logic [ROW_BITS-1:0]    row_a_data;
    logic                   row_a_valid;
    logic                   row_a_ready;
    logic                   row_a_help;
    logic [ROW_W-1:0]       row_a_idx;
    logic                   row_a_last;

    logic [ROW_BITS-1:0]    row_b_data;
    logic                   row_b_valid;
    logic                   row_b_ready;
    logic                   row_b_help;
    logic [ROW_W-1:0]       row_b_idx;
    logic                   row_b_last;

    logic                   block_done;
    logic                   help_err;

    modport master (
        input  empty, cache_data, row_a_ready, row_b_ready,
        output read_req,
        output row_a_data, row_a_valid, row_a_help, row_a_idx, row_a_last,
        output row_b_data, row_b_valid, row_b_help, row_b_idx, row_b_last,
        output block_done, help_err
    );

    modport slave (
        output empty, cache_data, row_a_ready, row_b_ready,
        input  read_req,
        input  row_a_data, row_a_valid, row_a_help, row_a_idx, row_a_last,
        input  row_b_data, row_b_valid, row_b_help, row_b_idx, row_b_last,
        input  block_done, help_err
    );
endinterface

// File: rtl/cache_row_dispatch.sv
// Pops 162-bit block-cache words and splits each into two independently drained
// 80-bit row lanes (A = block 0/1, B = block 2/3) with row index, last-row and help tags.
module cache_row_dispatch #(
    parameter int DATA_WIDTH   = 8,
    parameter int BLOCK_WIDTH  = 10,
    parameter int BLOCK_HEIGTH = 10,
    parameter int CACHE_WIDTH  = 2 + 2*DATA_WIDTH*BLOCK_WIDTH,
    parameter int ROW_W        = $clog2(BLOCK_HEIGTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_en,
    cache_row_dispatch_if.master bus
);
    localparam int               ROW_BITS = DATA_WIDTH*BLOCK_WIDTH;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(BLOCK_HEIGTH-1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic                read_req_next;
    logic                capture;
    logic [ROW_W-1:0]    row_cnt_reg;
    logic [ROW_W-1:0]    idx_reg;
    logic [1:0]          ref_help_reg;
    logic                help_err_reg;
    logic [1:0]          word_help;

    // Per-lane views; bit 0 / element 0 is lane A, bit 1 / element 1 is lane B.
    logic [1:0]          lane_ready;
    logic [1:0]          lane_valid;
    logic [1:0]          lane_help;
    logic [1:0]          lane_hs;
    logic [1:0]          lane_free;
    logic [ROW_BITS-1:0] lane_data [2];

    // The word is only on cache_data during WAIT; a frozen clock enable delays the capture.
    assign capture    = clk_en && (state_reg == WAIT);
    assign lane_ready = {bus.row_b_ready, bus.row_a_ready};
    // {help A, help B}
    assign word_help  = bus.cache_data[CACHE_WIDTH-1 -: 2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic                valid_reg;
            logic                help_reg;
            logic [ROW_BITS-1:0] data_reg;

            // Lane register: load on capture, drop valid on handshake, otherwise hold.
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    help_reg  <= 1'b0;
                    data_reg  <= '0;
                end else if (capture) begin
                    valid_reg <= 1'b1;
                    help_reg  <= bus.cache_data[CACHE_WIDTH-1-gi];
                    data_reg  <= bus.cache_data[ROW_BITS*(2-gi)-1 -: ROW_BITS];
                end else if (lane_hs[gi]) begin
                    valid_reg <= 1'b0;
                end
            end

            assign lane_valid[gi] = valid_reg;
            assign lane_help[gi]  = help_reg;
            assign lane_data[gi]  = data_reg;
            assign lane_hs[gi]    = clk_en && valid_reg && lane_ready[gi];
            assign lane_free[gi]  = !valid_reg || lane_hs[gi];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and pop request; nothing moves while the clock enable is low.
    always_comb begin
        state_next    = state_reg;
        read_req_next = 1'b0;
        if (clk_en) begin
            case (state_reg)
                IDLE: begin
                    if (!bus.empty) begin
                        read_req_next = 1'b1;
                        state_next    = WAIT;
                    end
                end
                WAIT: begin
                    state_next = HOLD;
                end
                HOLD: begin
                    if (&lane_free) begin
                        if (!bus.empty) begin
                            read_req_next = 1'b1;
                            state_next    = WAIT;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Row counter, presented index and help consistency tracking within a block.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_cnt_reg  <= '0;
            idx_reg      <= '0;
            ref_help_reg <= 2'b00;
            help_err_reg <= 1'b0;
        end else if (capture) begin
            idx_reg     <= row_cnt_reg;
            row_cnt_reg <= (row_cnt_reg == LAST_ROW) ? '0 : row_cnt_reg + 1'b1;
            if (row_cnt_reg == '0) begin
                ref_help_reg <= word_help;
            end else if (word_help != ref_help_reg) begin
                help_err_reg <= 1'b1;
            end
        end
    end

    assign bus.read_req    = read_req_next;

    assign bus.row_a_data  = lane_data[0];
    assign bus.row_a_valid = lane_valid[0];
    assign bus.row_a_help  = lane_help[0];
    assign bus.row_a_idx   = idx_reg;
    assign bus.row_a_last  = (idx_reg == LAST_ROW);

    assign bus.row_b_data  = lane_data[1];
    assign bus.row_b_valid = lane_valid[1];
    assign bus.row_b_help  = lane_help[1];
    assign bus.row_b_idx   = idx_reg;
    assign bus.row_b_last  = (idx_reg == LAST_ROW);

    // Both lanes of one word carry the same index, so the block ends when the final
    // outstanding last-row lane handshakes.
    assign bus.block_done  = (state_reg == HOLD) && (idx_reg == LAST_ROW) &&
                             (&lane_free) && (|lane_hs);
    assign bus.help_err    = help_err_reg;
endmodule
